// File: rtl/sub_unit_arbiter.sv
// Round-robin arbiter sharing one memory sub-unit responder between NUM_REQUESTERS
// controllers; a tag FIFO routes in-order read responses back to the issuer.
module sub_unit_arbiter #(
  parameter int NUM_REQUESTERS  = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQUESTERS-1:0]                 req_request,
  input  logic [NUM_REQUESTERS-1:0]                 req_new_request,
  input  logic [NUM_REQUESTERS-1:0][31:0]           req_addr,
  input  logic [NUM_REQUESTERS-1:0]                 req_re,
  input  logic [NUM_REQUESTERS-1:0]                 req_we,
  input  logic [NUM_REQUESTERS-1:0][3:0]            req_be,
  input  logic [NUM_REQUESTERS-1:0][31:0]           req_data_in,
  output logic [NUM_REQUESTERS-1:0]                 req_ready,
  output logic [31:0]                               req_data_out,
  output logic [NUM_REQUESTERS-1:0]                 req_data_valid,
  output logic                                      sub_new_request,
  output logic [31:0]                               sub_addr,
  output logic                                      sub_re,
  output logic                                      sub_we,
  output logic [3:0]                                sub_be,
  output logic [31:0]                               sub_data_in,
  input  logic [31:0]                               sub_data_out,
  input  logic                                      sub_data_valid,
  input  logic                                      sub_ready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]      outstanding,
  output logic                                      idle
);
  localparam int TAG_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

  logic [TAG_W-1:0] ptr_q, ptr_d, grant, g_hi, g_lo;
  logic             found_hi, found_lo, any_req;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [MAX_OUTSTANDING-1:0][TAG_W-1:0] tags_q;
  logic             fifo_full, fifo_empty, ready_ok, accept, push, pop;

  // Cyclic search from ptr: indices >= ptr outrank the wrapped-around ones.
  always_comb begin
    g_hi = '0; g_lo = '0; found_hi = 1'b0; found_lo = 1'b0;
    for (int i = NUM_REQUESTERS-1; i >= 0; i--) begin
      if (req_request[i]) begin
        if (TAG_W'(i) >= ptr_q) begin
          g_hi = TAG_W'(i); found_hi = 1'b1;
        end else begin
          g_lo = TAG_W'(i); found_lo = 1'b1;
        end
      end
    end
    grant   = found_hi ? g_hi : g_lo;
    any_req = found_hi | found_lo;
  end

  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign ready_ok   = ~rst & sub_ready & ~fifo_full;
  assign accept     = any_req & ready_ok & req_new_request[grant];
  assign push       = accept & req_re[grant];
  assign pop        = ~rst & sub_data_valid & ~fifo_empty;

  always_comb begin
    req_ready = '0;
    if (any_req && ready_ok) req_ready[grant] = 1'b1;
    req_data_valid = '0;
    if (pop) req_data_valid[tags_q[rd_ptr_q]] = 1'b1;
  end

  assign sub_new_request = accept;
  assign sub_addr        = req_addr[grant];
  assign sub_re          = req_re[grant];
  assign sub_we          = req_we[grant];
  assign sub_be          = req_be[grant];
  assign sub_data_in     = req_data_in[grant];
  assign req_data_out    = sub_data_out;
  assign outstanding     = count_q;
  assign idle            = fifo_empty;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (grant == TAG_W'(NUM_REQUESTERS-1)) ? '0 : grant + 1'b1;
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : rd_ptr_q + 1'b1;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (push) tags_q[wr_ptr_q] <= grant;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((req_new_request & ~req_ready) == '0)
        else $error("issue strobe without ready: %b", req_new_request & ~req_ready);
      assert (!(sub_data_valid && fifo_empty))
        else $error("read response with no read outstanding");
    end
  end
`endif
endmodule

// File: tb/tb_sub_unit_arbiter.sv
// Directed bench for sub_unit_arbiter; read issues push the expected requester
// onto a scoreboard queue, responses pop and check routing.
module tb_sub_unit_arbiter;
  localparam int NR = 2;
  localparam int MO = 4;

  logic                 clk, rst;
  logic [NR-1:0]        req_request, req_new_request, req_re, req_we;
  logic [NR-1:0][31:0]  req_addr, req_data_in;
  logic [NR-1:0][3:0]   req_be;
  logic [NR-1:0]        req_ready, req_data_valid;
  logic [31:0]          req_data_out, sub_addr, sub_data_in, sub_data_out;
  logic                 sub_new_request, sub_re, sub_we, sub_data_valid, sub_ready;
  logic [3:0]           sub_be;
  logic [2:0]           outstanding;
  logic                 idle;

  sub_unit_arbiter #(.NUM_REQUESTERS(NR), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst),
    .req_request(req_request), .req_new_request(req_new_request),
    .req_addr(req_addr), .req_re(req_re), .req_we(req_we), .req_be(req_be),
    .req_data_in(req_data_in), .req_ready(req_ready), .req_data_out(req_data_out),
    .req_data_valid(req_data_valid), .sub_new_request(sub_new_request),
    .sub_addr(sub_addr), .sub_re(sub_re), .sub_we(sub_we), .sub_be(sub_be),
    .sub_data_in(sub_data_in), .sub_data_out(sub_data_out),
    .sub_data_valid(sub_data_valid), .sub_ready(sub_ready),
    .outstanding(outstanding), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int exp_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    req_request = '0; req_new_request = '0; req_re = '0; req_we = '0;
    sub_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; exp_q.delete();
  endtask

  // Drive one response this cycle and check its routing against the scoreboard head.
  task automatic resp(input logic [31:0] d, input string tag);
    int g;
    sub_data_valid = 1'b1; sub_data_out = d; #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s observed=response expected=no_outstanding_read", tag);
    end else begin
      g = exp_q.pop_front();
      chk({tag, "_vld"}, req_data_valid, 64'(1 << g));
      chk({tag, "_dat"}, req_data_out, d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; quiet(); sub_ready = 1'b1; sub_data_out = '0;
    req_addr = '0; req_data_in = '0; req_be = '0;
    req_request = 2'b11;
    #3;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_dvalid", req_data_valid, 2'b00);
    chk("rst_subnew", sub_new_request, 1'b0);
    chk("rst_outst", outstanding, 3'd0);
    chk("rst_idle", idle, 1'b1);
    do_reset(); quiet();

    // single read by requester 0, response two cycles later
    req_request = 2'b01; req_new_request = 2'b01; req_re = 2'b01;
    req_addr[0] = 32'h100; #1;
    chk("t1_subnew", sub_new_request, 1'b1);
    chk("t1_addr", sub_addr, 32'h100);
    chk("t1_ready", req_ready, 2'b01);
    chk("t1_out0", outstanding, 3'd0);
    exp_q.push_back(0);
    tick(); quiet();
    chk("t1_out1", outstanding, 3'd1);
    tick();
    resp(32'hDEADBEEF, "t1_rsp");
    tick(); quiet();
    chk("t1_out_end", outstanding, 3'd0);
    chk("t1_idle", idle, 1'b1);

    // back-to-back alternating reads from both requesters until full
    do_reset(); quiet();
    exp_g = 0;
    for (int i = 0; i < 4; i++) begin
      req_request = 2'b11; req_re = 2'b11;
      req_addr[0] = 32'h1000 + 32'(i); req_addr[1] = 32'h2000 + 32'(i);
      req_new_request = 2'(1 << exp_g); #1;
      chk($sformatf("t2_ready%0d", i), req_ready, 64'(1 << exp_g));
      chk($sformatf("t2_addr%0d", i), sub_addr, (exp_g == 0) ? 32'h1000 + 32'(i) : 32'h2000 + 32'(i));
      exp_q.push_back(exp_g);
      tick();
      exp_g = 1 - exp_g;
    end
    // full: response this cycle must not free a slot for issue
    req_new_request = '0;
    chk("t3_out4", outstanding, 3'd4);
    resp(32'hD0D0D0D0, "t3_rsp0");
    chk("t3_ready_full", req_ready, 2'b00);
    tick(); sub_data_valid = 1'b0; #1;
    chk("t3_out3", outstanding, 3'd3);
    chk("t3_ready_back", req_ready, 2'b01);
    req_request = '0; req_re = '0;
    resp(32'hD1D1D1D1, "t3_rsp1"); tick();
    resp(32'hD2D2D2D2, "t3_rsp2"); tick();
    resp(32'hD3D3D3D3, "t3_rsp3"); tick();
    quiet(); #1;
    chk("t3_out_end", outstanding, 3'd0);

    // simultaneous push and pop across wrapped FIFO pointers
    req_request = 2'b10; req_new_request = 2'b10; req_re = 2'b10;
    exp_q.push_back(1);
    tick();
    req_request = 2'b01; req_new_request = 2'b01; req_re = 2'b01;
    resp(32'h5A5A0001, "t4_rsp_a");
    exp_q.push_back(0);
    tick(); quiet(); #1;
    chk("t4_out_same", outstanding, 3'd1);
    resp(32'h5A5A0002, "t4_rsp_b");
    tick(); quiet(); #1;
    chk("t4_out_end", outstanding, 3'd0);

    // write from requester 1 is forwarded and receives no tag
    req_request = 2'b10; req_new_request = 2'b10; req_we = 2'b10;
    req_addr[1] = 32'h200; req_be[1] = 4'b0011; req_data_in[1] = 32'h1234; #1;
    chk("t5_subnew", sub_new_request, 1'b1);
    chk("t5_we", sub_we, 1'b1);
    chk("t5_re", sub_re, 1'b0);
    chk("t5_be", sub_be, 4'b0011);
    chk("t5_data", sub_data_in, 32'h1234);
    chk("t5_addr", sub_addr, 32'h200);
    tick(); quiet(); #1;
    chk("t5_out", outstanding, 3'd0);
    chk("t5_dvalid", req_data_valid, 2'b00);

    // responder not ready: no grants, priority held
    sub_ready = 1'b0; req_request = 2'b11; #1;
    chk("t6_ready", req_ready, 2'b00);
    chk("t6_subnew", sub_new_request, 1'b0);
    tick(); tick();
    sub_ready = 1'b1; #1;
    chk("t6_ptr_held", req_ready, 2'b01);
    quiet();

    // asynchronous reset with three reads in flight
    for (int i = 0; i < 3; i++) begin
      req_request = 2'b01; req_new_request = 2'b01; req_re = 2'b01;
      tick();
    end
    quiet();
    chk("t7_out3", outstanding, 3'd3);
    #2 rst = 1'b1; #1;
    chk("t7_rst_out", outstanding, 3'd0);
    chk("t7_rst_idle", idle, 1'b1);
    exp_q.delete();
    sub_data_valid = 1'b1; sub_data_out = 32'hBADBAD00; #1;
    chk("t7_rst_dvalid", req_data_valid, 2'b00);
    sub_data_valid = 1'b0;
    tick(); rst = 1'b0; #1;
    chk("t7_post_out", outstanding, 3'd0);
    req_request = 2'b10; req_new_request = 2'b10; req_re = 2'b10;
    exp_q.push_back(1);
    tick(); quiet();
    chk("t7_post_out1", outstanding, 3'd1);
    tick();
    resp(32'hCAFE0001, "t7_rsp");
    tick(); quiet(); #1;
    chk("t7_post_idle", idle, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sub_unit_arbiter.md
Name: sub_unit_arbiter

Overview:
Shares one memory sub-unit responder, which speaks the memory_sub_unit handshake, between NUM_REQUESTERS controllers, for example fetch and load-store sharing a local memory. Arbitration is round-robin among requesters that signal intent. A tag FIFO records which requester issued each read, so in-order read responses are routed back to the correct requester. The block sits between the requesting units and a single responder port.

Parameters:
NUM_REQUESTERS, 2, number of controllers sharing the responder (2..4).
MAX_OUTSTANDING, 4, depth of the read tag FIFO; must be a power of two.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_request  input  NUM_REQUESTERS  per-requester intent to issue; level, independent of ready
req_new_request  input  NUM_REQUESTERS  issue strobe; legal only when req_request[i] and req_ready[i] are both high
req_addr  input  32*NUM_REQUESTERS  address; slice i
req_re  input  NUM_REQUESTERS  read enable
req_we  input  NUM_REQUESTERS  write enable
req_be  input  4*NUM_REQUESTERS  byte enables; slice i
req_data_in  input  32*NUM_REQUESTERS  write data; slice i
req_ready  output  NUM_REQUESTERS  grant/ready to requester i
req_data_out  output  32  read data, broadcast to all requesters
req_data_valid  output  NUM_REQUESTERS  one-hot read-response strobe
sub_new_request  output  1  to responder
sub_addr  output  32  to responder
sub_re  output  1  to responder
sub_we  output  1  to responder
sub_be  output  4  to responder
sub_data_in  output  32  to responder
sub_data_out  input  32  responder read data
sub_data_valid  input  1  responder read-response strobe
sub_ready  input  1  responder can accept a request
outstanding  output  $clog2(MAX_OUTSTANDING+1)  number of reads in flight
idle  output  1  high when outstanding == 0

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- State: round-robin pointer ptr, tag FIFO (entries of $clog2(NUM_REQUESTERS) bits), FIFO read/write pointers, count.
- Reset values: ptr=0, FIFO empty, count=0. While rst is high: req_ready=0, req_data_valid=0, sub_new_request=0, outstanding=0, idle=1.
- Grant (combinational): grant = first i, searching cyclically from ptr, with req_request[i]=1.
  - req_ready[grant] = sub_ready & ~fifo_full. Every other req_ready bit is 0.
  - req_ready never depends on req_new_request, so there is no combinational loop.
- Request mux (zero-latency, combinational):
  - sub_new_request = req_new_request[grant] & req_ready[grant].
  - sub_addr, sub_re, sub_we, sub_be and sub_data_in take slice grant.
  - A req_new_request[j] without ready is ignored; this is flagged by an assertion.
- Pointer update: on an accepted issue by requester g, ptr <= (g+1) mod NUM_REQUESTERS. Otherwise ptr holds. With no issue, the same requester keeps priority.
- Tag push: on an accepted issue with re=1, push g into the FIFO. Writes do not push and receive no response.
- fifo_full is count == MAX_OUTSTANDING. A pop in the same cycle does not relieve full, so ready stays low that cycle.
- Response routing: on sub_data_valid:
  - pop the FIFO head h;
  - req_data_valid[h]=1 in the same cycle;
  - req_data_out = sub_data_out, always passed through.
- sub_data_valid with the FIFO empty: no requester strobed, no state change, assertion fires.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo MAX_OUTSTANDING.
- outstanding = count. idle = (count == 0).
- Reset mid-operation clears all tags; responses in flight are dropped. The responder shares rst.

Test Plan:
- Single requester 0 reads addr 0x100; responder returns 0xDEADBEEF 2 cycles later -> sub_addr=0x100 in the issue cycle, req_data_valid=2'b01 with req_data_out=0xDEADBEEF, outstanding goes 0->1->0.
- Both req_request high every cycle, both issuing reads back-to-back, sub_ready=1 -> grants alternate 0,1,0,1; responses D0..D3 are routed to valid patterns 01,10,01,10.
- 4 outstanding reads with no response -> req_ready=0 on the 5th cycle even with sub_data_valid asserted that cycle; ready returns the following cycle; outstanding = 4 then 3.
- Requester 1 issues a write (we=1, be=4'b0011, data 0x1234) -> forwarded unchanged, no tag pushed, outstanding stays 0, no req_data_valid.
- sub_ready=0 with req_request=2'b11 -> req_ready=2'b00, ptr unchanged, sub_new_request=0.
- rst asserted with 3 reads outstanding -> outstanding=0 and idle=1 immediately (asynchronous); a later sub_data_valid produces req_data_valid=0.
